pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Program counter and return-address stack for the CPU datapath; sits directly downstream of the control unit and consumes its PC/stack strobes.
- Holds the PC, presents fetch addresses to instruction memory, and applies branch targets taken from the instruction word.
- Implements JMP (push return address, then branch) and RET (pop, then reload PC) with an internal LIFO.

Parameters:
ADDR_WIDTH, 10, width of PC, branch target and stack entries
STACK_DEPTH, 8, number of return-address entries (power of two, >=2)
SP_WIDTH, 4, stack pointer width, must equal clog2(STACK_DEPTH)+1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
get_address_from_pc  input  1  latch PC onto instr_addr
Increm_PC  input  1  PC <= PC+1
pc_save_address_from_instr_mem  input  1  PC <= branch_addr
pc_save_address_from_data_mem  input  1  PC <= ret_addr
PUSH  input  1  push current PC onto stack
POP  input  1  pop top of stack into ret_addr
branch_addr  input  ADDR_WIDTH  branch/jump target field of current instruction
instr_addr  output  ADDR_WIDTH  registered fetch address to instruction memory
instr_addr_valid  output  1  one-cycle pulse when instr_addr is updated
pc_value  output  ADDR_WIDTH  current PC (debug/observe)
ret_addr  output  ADDR_WIDTH  last popped return address
sp  output  SP_WIDTH  number of valid stack entries
stack_empty  output  1  sp==0
stack_full  output  1  sp==STACK_DEPTH
stack_err  output  1  sticky: overflow, underflow or PUSH+POP collision

Behaviour:
- Reset (async, rst=1): pc=0, instr_addr=0, instr_addr_valid=0, ret_addr=0, sp=0, stack_empty=1, stack_full=0, stack_err=0; stack contents undefined, never read while empty. Only rst clears stack_err.
- All strobes are sampled on the rising edge; every effect is visible the cycle after the strobe (latency 1).
- Fetch: get_address_from_pc=1 -> instr_addr <= pc (pre-update value when combined with a PC strobe in the same cycle); instr_addr_valid=1 for exactly that next cycle, else 0.
- PC update priority, highest first:
  - pc_save_address_from_instr_mem: pc <= branch_addr.
  - pc_save_address_from_data_mem: pc <= ret_addr. This uses the registered ret_addr; a POP in the same cycle does not forward.
  - Increm_PC: pc <= pc+1 mod 2^ADDR_WIDTH, so 0x3FF wraps to 0x000.
  - Otherwise pc holds.
- PUSH alone:
  - If not full: stack[sp] <= pc (pre-update value), sp <= sp+1.
  - If full: no change to stack or sp; stack_err <= 1.
- POP alone:
  - If not empty: ret_addr <= stack[sp-1], sp <= sp-1.
  - If empty: ret_addr and sp unchanged; stack_err <= 1.
- PUSH and POP in the same cycle: stack, sp and ret_addr unchanged; stack_err <= 1. PC logic is unaffected.
- stack_empty and stack_full are registered and consistent with sp every cycle.
- Control sequences supported:
  - Fetch: GET_LINE (get_address_from_pc), then INCREMENT (Increm_PC).
  - JMP: PUSH, idle cycle, then pc_save_address_from_instr_mem. The return address pushed is the already-incremented PC.
  - RET: POP, then pc_save_address_from_data_mem.
- Reset asserted mid-sequence (e.g. between POP and the reload) discards all state immediately; no pending action survives.

Test Plan:
1. Reset, then 3× (get_address_from_pc, Increm_PC) -> instr_addr 0,1,2 each with a 1-cycle valid pulse; pc=3; sp=0, stack_empty=1.
2. pc=5: PUSH, then pc_save_address_from_instr_mem with branch_addr=0x040 -> sp=1, pc=0x040. Then POP, then pc_save_address_from_data_mem -> ret_addr=5, pc=5, sp=0, stack_err=0.
3. Push 8 distinct PCs (10..17) -> stack_full=1, sp=8. A 9th PUSH -> sp stays 8, stack_err=1. 8 POPs -> ret_addr 17..10 in LIFO order, stack_empty=1.
4. From reset, POP on empty -> ret_addr=0, sp=0, stack_err=1. stack_err stays 1 through further legal ops until rst.
5. pc=0x3FF with Increm_PC -> pc=0x000. Same cycle pc_save_address_from_instr_mem(0x123) + Increm_PC -> pc=0x123 (priority).
6. sp=2: PUSH+POP in the same cycle -> sp=2, ret_addr unchanged, stack_err=1. Asynchronous rst pulse mid-cycle -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter with fetch-address register and a return-address LIFO.
// All strobes take effect on the next rising edge.
module pc_stack_unit #(
   parameter int ADDR_WIDTH  = 10,
   parameter int STACK_DEPTH = 8,
   parameter int SP_WIDTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  get_address_from_pc,
   input  logic                  Increm_PC,
   input  logic                  pc_save_address_from_instr_mem,
   input  logic                  pc_save_address_from_data_mem,
   input  logic                  PUSH,
   input  logic                  POP,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
   output logic [ADDR_WIDTH-1:0] instr_addr,
   output logic                  instr_addr_valid,
   output logic [ADDR_WIDTH-1:0] pc_value,
   output logic [ADDR_WIDTH-1:0] ret_addr,
   output logic [SP_WIDTH-1:0]   sp,
   output logic                  stack_empty,
   output logic                  stack_full,
   output logic                  stack_err
);

   localparam int                     IDX_W   = SP_WIDTH - 1;
   localparam logic [SP_WIDTH-1:0]    SP_ONE  = SP_WIDTH'(1);
   localparam logic [SP_WIDTH-1:0]    SP_FULL = SP_WIDTH'(STACK_DEPTH);
   localparam logic [ADDR_WIDTH-1:0]  PC_ONE  = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] instr_addr_q, instr_addr_d;
   logic                  instr_valid_q;
   logic [ADDR_WIDTH-1:0] ret_addr_q, ret_addr_d;
   logic [SP_WIDTH-1:0]   sp_q, sp_d;
   logic                  empty_q, full_q, err_q, err_d;
   logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

   logic                  push_ok, pop_ok;
   logic [SP_WIDTH-1:0]   sp_dec;
   logic [IDX_W-1:0]      wr_idx, rd_idx;

   // A simultaneous PUSH+POP is treated as a collision: neither side acts.
   assign push_ok = PUSH && !POP && !full_q;
   assign pop_ok  = POP && !PUSH && !empty_q;
   assign sp_dec  = sp_q - SP_ONE;
   assign wr_idx  = sp_q[IDX_W-1:0];
   assign rd_idx  = sp_dec[IDX_W-1:0];

   always_comb begin
      pc_d = pc_q;
      if (pc_save_address_from_instr_mem)
         pc_d = branch_addr;
      else if (pc_save_address_from_data_mem)
         pc_d = ret_addr_q;
      else if (Increm_PC)
         pc_d = pc_q + PC_ONE;

      instr_addr_d = get_address_from_pc ? pc_q : instr_addr_q;

      sp_d       = sp_q;
      ret_addr_d = ret_addr_q;
      if (push_ok)
         sp_d = sp_q + SP_ONE;
      else if (pop_ok) begin
         sp_d       = sp_dec;
         ret_addr_d = stack_q[rd_idx];
      end

      err_d = err_q || (PUSH && POP) || (PUSH && full_q) || (POP && empty_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= '0;
         instr_addr_q  <= '0;
         instr_valid_q <= 1'b0;
         ret_addr_q    <= '0;
         sp_q          <= '0;
         empty_q       <= 1'b1;
         full_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         instr_addr_q  <= instr_addr_d;
         instr_valid_q <= get_address_from_pc;
         ret_addr_q    <= ret_addr_d;
         sp_q          <= sp_d;
         empty_q       <= (sp_d == '0);
         full_q        <= (sp_d == SP_FULL);
         err_q         <= err_d;
      end
   end

   // Entries are only read below sp, so the storage needs no reset.
   always_ff @(posedge clk) begin
      if (push_ok)
         stack_q[wr_idx] <= pc_q;
   end

   assign instr_addr       = instr_addr_q;
   assign instr_addr_valid = instr_valid_q;
   assign pc_value         = pc_q;
   assign ret_addr         = ret_addr_q;
   assign sp               = sp_q;
   assign stack_empty      = empty_q;
   assign stack_full       = full_q;
   assign stack_err        = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: vector table for PC/fetch behaviour, hand-written
// sequences for stack fill/drain, error stickiness and asynchronous reset.
module tb_pc_stack_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       gap = 1'b0, inc = 1'b0, bri = 1'b0, brd = 1'b0, push = 1'b0, pop = 1'b0;
   logic [9:0] branch_addr = '0;
   logic [9:0] instr_addr, pc_value, ret_addr;
   logic       instr_addr_valid, stack_empty, stack_full, stack_err;
   logic [3:0] sp;

   int total = 0;
   int bad   = 0;
   logic [37:0] exp_q[$];

   localparam logic [5:0] C_IDLE = 6'b000000;
   localparam logic [5:0] C_GAP  = 6'b100000;
   localparam logic [5:0] C_INC  = 6'b010000;
   localparam logic [5:0] C_BRI  = 6'b001000;
   localparam logic [5:0] C_BRD  = 6'b000100;
   localparam logic [5:0] C_PUSH = 6'b000010;
   localparam logic [5:0] C_POP  = 6'b000001;

   typedef struct {
      logic [5:0]  ctl;
      logic [9:0]  ba;
      logic [37:0] exp;
   } vec_t;

   vec_t tbl[17];

   pc_stack_unit #(.ADDR_WIDTH(10), .STACK_DEPTH(8), .SP_WIDTH(4)) dut (
      .clk                            (clk),
      .rst                            (rst),
      .get_address_from_pc            (gap),
      .Increm_PC                      (inc),
      .pc_save_address_from_instr_mem (bri),
      .pc_save_address_from_data_mem  (brd),
      .PUSH                           (push),
      .POP                            (pop),
      .branch_addr                    (branch_addr),
      .instr_addr                     (instr_addr),
      .instr_addr_valid               (instr_addr_valid),
      .pc_value                       (pc_value),
      .ret_addr                       (ret_addr),
      .sp                             (sp),
      .stack_empty                    (stack_empty),
      .stack_full                     (stack_full),
      .stack_err                      (stack_err)
   );

   always #5 clk = ~clk;

   function automatic logic [37:0] ex(input logic [9:0] pc, input logic [9:0] ia, input logic v,
                                      input logic [9:0] ra, input logic [3:0] s,
                                      input logic e, input logic f, input logic er);
      return {pc, ia, v, ra, s, e, f, er};
   endfunction

   task automatic check(input string nm);
      logic [37:0] act;
      logic [37:0] want;
      act = {pc_value, instr_addr, instr_addr_valid, ret_addr, sp, stack_empty, stack_full, stack_err};
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: no expected entry queued", nm);
      end else begin
         want = exp_q.pop_front();
         if (act !== want) begin
            bad++;
            $display("FAIL %s: got pc=%h ia=%h v=%b ra=%h sp=%0d e=%b f=%b err=%b, want pc=%h ia=%h v=%b ra=%h sp=%0d e=%b f=%b err=%b",
                     nm, act[37:28], act[27:18], act[17], act[16:7], act[6:3], act[2], act[1], act[0],
                     want[37:28], want[27:18], want[17], want[16:7], want[6:3], want[2], want[1], want[0]);
         end
      end
   endtask

   task automatic step(input string nm, input logic [5:0] ctl, input logic [9:0] ba, input logic [37:0] e);
      {gap, inc, bri, brd, push, pop} = ctl;
      branch_addr = ba;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check(nm);
      @(negedge clk);
      {gap, inc, bri, brd, push, pop} = C_IDLE;
   endtask

   task automatic do_reset();
      {gap, inc, bri, brd, push, pop} = C_IDLE;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(ex(10'd0, 10'd0, 1'b0, 10'd0, 4'd0, 1'b1, 1'b0, 1'b0));
      #1;
      check("reset_state");
   endtask

   initial begin
      tbl[0]  = '{C_GAP,         10'h000, ex(10'h000, 10'h000, 1'b1, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[1]  = '{C_INC,         10'h000, ex(10'h001, 10'h000, 1'b0, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[2]  = '{C_GAP,         10'h000, ex(10'h001, 10'h001, 1'b1, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[3]  = '{C_INC,         10'h000, ex(10'h002, 10'h001, 1'b0, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[4]  = '{C_GAP,         10'h000, ex(10'h002, 10'h002, 1'b1, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[5]  = '{C_INC,         10'h000, ex(10'h003, 10'h002, 1'b0, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[6]  = '{C_GAP | C_INC, 10'h000, ex(10'h004, 10'h003, 1'b1, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[7]  = '{C_INC,         10'h000, ex(10'h005, 10'h003, 1'b0, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[8]  = '{C_PUSH,        10'h000, ex(10'h005, 10'h003, 1'b0, 10'h000, 4'd1, 1'b0, 1'b0, 1'b0)};
      tbl[9]  = '{C_BRI,         10'h040, ex(10'h040, 10'h003, 1'b0, 10'h000, 4'd1, 1'b0, 1'b0, 1'b0)};
      tbl[10] = '{C_POP,         10'h000, ex(10'h040, 10'h003, 1'b0, 10'h005, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[11] = '{C_BRD,         10'h000, ex(10'h005, 10'h003, 1'b0, 10'h005, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[12] = '{C_BRI,         10'h3FF, ex(10'h3FF, 10'h003, 1'b0, 10'h005, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[13] = '{C_INC,         10'h000, ex(10'h000, 10'h003, 1'b0, 10'h005, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[14] = '{C_BRI | C_INC, 10'h123, ex(10'h123, 10'h003, 1'b0, 10'h005, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[15] = '{C_BRD | C_INC, 10'h000, ex(10'h005, 10'h003, 1'b0, 10'h005, 4'd0, 1'b1, 1'b0, 1'b0)};
      tbl[16] = '{C_BRI | C_BRD, 10'h2AA, ex(10'h2AA, 10'h003, 1'b0, 10'h005, 4'd0, 1'b1, 1'b0, 1'b0)};

      do_reset();

      for (int i = 0; i < 17; i++)
         step($sformatf("vec%0d", i), tbl[i].ctl, tbl[i].ba, tbl[i].exp);

      // Fill the stack with PCs 10..17, overflow once, then drain in LIFO order.
      step("set_pc10", C_BRI, 10'd10, ex(10'd10, 10'h003, 1'b0, 10'h005, 4'd0, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < 8; i++)
         step($sformatf("fill%0d", i), C_PUSH | C_INC, 10'd0,
              ex(10'(11 + i), 10'h003, 1'b0, 10'h005, 4'(i + 1), 1'b0, (i == 7), 1'b0));
      step("overflow", C_PUSH, 10'd0, ex(10'd18, 10'h003, 1'b0, 10'h005, 4'd8, 1'b0, 1'b1, 1'b1));
      // Reload with POP in the same cycle must use the old ret_addr (5), not 17.
      step("drain0_noforward", C_POP | C_BRD, 10'd0, ex(10'd5, 10'h003, 1'b0, 10'd17, 4'd7, 1'b0, 1'b0, 1'b1));
      for (int i = 1; i < 8; i++)
         step($sformatf("drain%0d", i), C_POP, 10'd0,
              ex(10'd5, 10'h003, 1'b0, 10'(17 - i), 4'(7 - i), (i == 7), 1'b0, 1'b1));

      // Underflow from reset, then error stays sticky through legal operations.
      do_reset();
      step("underflow", C_POP,  10'd0, ex(10'd0, 10'd0, 1'b0, 10'd0, 4'd0, 1'b1, 1'b0, 1'b1));
      step("sticky_gap",  C_GAP,  10'd0, ex(10'd0, 10'd0, 1'b1, 10'd0, 4'd0, 1'b1, 1'b0, 1'b1));
      step("sticky_push", C_PUSH, 10'd0, ex(10'd0, 10'd0, 1'b0, 10'd0, 4'd1, 1'b0, 1'b0, 1'b1));
      step("sticky_pop",  C_POP,  10'd0, ex(10'd0, 10'd0, 1'b0, 10'd0, 4'd0, 1'b1, 1'b0, 1'b1));
      step("sticky_inc",  C_INC,  10'd0, ex(10'd1, 10'd0, 1'b0, 10'd0, 4'd0, 1'b1, 1'b0, 1'b1));

      // Collision at sp=2, then asynchronous reset in the middle of a cycle.
      do_reset();
      step("c_push0", C_PUSH | C_INC, 10'd0, ex(10'd1, 10'd0, 1'b0, 10'd0, 4'd1, 1'b0, 1'b0, 1'b0));
      step("c_push1", C_PUSH | C_INC, 10'd0, ex(10'd2, 10'd0, 1'b0, 10'd0, 4'd2, 1'b0, 1'b0, 1'b0));
      step("c_pop",   C_POP,          10'd0, ex(10'd2, 10'd0, 1'b0, 10'd1, 4'd1, 1'b0, 1'b0, 1'b0));
      step("c_push2", C_PUSH,         10'd0, ex(10'd2, 10'd0, 1'b0, 10'd1, 4'd2, 1'b0, 1'b0, 1'b0));
      step("collide", C_PUSH | C_POP | C_INC, 10'd0, ex(10'd3, 10'd0, 1'b0, 10'd1, 4'd2, 1'b0, 1'b0, 1'b1));
      step("after_collide_pop", C_POP, 10'd0, ex(10'd3, 10'd0, 1'b0, 10'd2, 4'd1, 1'b0, 1'b0, 1'b1));

      #1 rst = 1'b1;
      #1;
      exp_q.push_back(ex(10'd0, 10'd0, 1'b0, 10'd0, 4'd0, 1'b1, 1'b0, 1'b0));
      check("async_reset");
      #1 rst = 1'b0;
      @(negedge clk);
      step("post_reset_idle", C_IDLE, 10'd0, ex(10'd0, 10'd0, 1'b0, 10'd0, 4'd0, 1'b1, 1'b0, 1'b0));
      step("post_reset_reload", C_BRD, 10'd0, ex(10'd0, 10'd0, 1'b0, 10'd0, 4'd0, 1'b1, 1'b0, 1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
